net_node_resolver: RTL and testbench

Sequential resolver for one extracted circuit net. It combines the 2-bit drive values produced by every transistor/pullup/pad model attached to the net into a single registered logic level using ratioed-NMOS rules. When no driver is active it retains stored charge, with optional leakage decay. It sits between the transistor model outputs and the gate/c*in inputs of the next evaluation step, clocked by the emulation clock.

---
 rtl/net_node_resolver_if.sv | 37 +++
 rtl/net_node_resolver.sv | 135 +++++++++++++
 tb/tb_net_node_resolver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/net_node_resolver_if.sv
// Bundle of the net resolver's evaluation/status signals.
//   master: drives en, i, err_clr; observes the resolved outputs.
//   slave : the resolver itself.
//   en          evaluation strobe
//   i           N packed 2-bit driver values
//   err_clr     clears the sticky illegal-drive flag
//   out         resolved net value (01 or 10)
//   floating    last evaluated cycle had no legal driver
//   decayed     out forced to 0 by leakage
//   changed     out changed on the previous edge
//   err_illegal sticky: a driver value of 11 was seen
`ifndef W
`define W 2
`endif

interface net_node_resolver_if #(
    parameter int unsigned N = 4
);
    logic              en;
    logic [N*`W-1:0]   i;
    logic              err_clr;
    logic [`W-1:0]     out;
    logic              floating;
    logic              decayed;
    logic              changed;
    logic              err_illegal;

    modport master (
        output en, i, err_clr,
        input  out, floating, decayed, changed, err_illegal
    );

    modport slave (
        input  en, i, err_clr,
        output out, floating, decayed, changed, err_illegal
    );
endinterface

// File: rtl/net_node_resolver.sv
// Ratioed-NMOS resolver for one extracted net. Combines the 2-bit drive
// values of all attached drivers into one registered level (pulldown beats
// pullup), keeps stored charge when undriven, and optionally leaks a stored
// 1 down to 0 after DECAY_CYCLES undriven evaluation cycles.
//   eclk  emulation clock
//   erst  synchronous active-high reset
//   bus   resolver signal bundle (slave side), see net_node_resolver_if
`ifndef W
`define W 2
`endif

module net_node_resolver #(
    parameter int unsigned N            = 4,
    parameter int unsigned DECAY_CYCLES = 0
) (
    input  logic                   eclk,
    input  logic                   erst,
    net_node_resolver_if.slave     bus
);
    localparam logic [`W-1:0] V0 = 2'b01;
    localparam logic [`W-1:0] V1 = 2'b10;

    // With decay disabled the counter only needs to hold 1.
    localparam int unsigned CMAX = (DECAY_CYCLES == 0) ? 1 : DECAY_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] CMAX_CNT  = CW'(CMAX);
    localparam logic [CW-1:0] DECAY_CNT = CW'(DECAY_CYCLES);

    typedef enum logic [1:0] {
        DRIVEN   = 2'd0,
        FLOATING = 2'd1,
        DECAYED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [`W-1:0]   out_q, out_d;
    logic            floating_q, floating_d;
    logic            decayed_q, decayed_d;
    logic            changed_q, changed_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;

    logic pd, pu, ill, drv;
    logic [`W-1:0] resolved;

    always_comb begin
        pd = 1'b0;
        pu = 1'b0;
        ill = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pd  = pd  | (bus.i[k*`W +: `W] == 2'b01);
            pu  = pu  | (bus.i[k*`W +: `W] == 2'b10);
            ill = ill | (bus.i[k*`W +: `W] == 2'b11);
        end
        drv = pd | pu;
        // Pulldown wins; with no driver the stored charge is kept.
        resolved = pd ? V0 : (pu ? V1 : out_q);
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        floating_d = floating_q;
        decayed_d  = decayed_q;
        cnt_d      = cnt_q;
        cnt_inc    = (cnt_q == CMAX_CNT) ? cnt_q : cnt_q + 1'b1;

        if (bus.en) begin
            floating_d = ~drv;
            if (drv) begin
                state_d   = DRIVEN;
                out_d     = resolved;
                decayed_d = 1'b0;
                cnt_d     = '0;
            end else begin
                unique case (state_q)
                    DRIVEN: begin
                        state_d = FLOATING;
                        cnt_d   = CW'(1);
                    end
                    FLOATING: begin
                        cnt_d = cnt_inc;
                        if (DECAY_CYCLES != 0 && cnt_inc == DECAY_CNT) begin
                            state_d   = DECAYED;
                            decayed_d = (out_q == V1);
                            out_d     = V0;
                        end
                    end
                    DECAYED: begin
                        out_d = V0;
                    end
                    default: state_d = DRIVEN;
                endcase
            end
        end

        changed_d = bus.en && (out_d != out_q);
        // Set has priority over clear; independent of en.
        err_d = ill ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge eclk) begin
        if (erst) begin
            state_q    <= DRIVEN;
            out_q      <= V0;
            floating_q <= 1'b0;
            decayed_q  <= 1'b0;
            changed_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            floating_q <= floating_d;
            decayed_q  <= decayed_d;
            changed_q  <= changed_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge eclk) begin
        if (!erst) begin
            assert (out_q == V0 || out_q == V1)
                else $error("net_node_resolver: illegal out value %b", out_q);
        end
    end

    assign bus.out         = out_q;
    assign bus.floating    = floating_q;
    assign bus.decayed     = decayed_q;
    assign bus.changed     = changed_q;
    assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_net_node_resolver.sv
`ifndef W
`define W 2
`endif

module tb_net_node_resolver;
    logic eclk = 1'b0;
    logic erst = 1'b1;

    net_node_resolver_if #(.N(4)) bus0 ();
    net_node_resolver_if #(.N(4)) bus1 ();

    net_node_resolver #(.N(4), .DECAY_CYCLES(0)) dut0 (
        .eclk(eclk), .erst(erst), .bus(bus0)
    );
    net_node_resolver #(.N(4), .DECAY_CYCLES(5)) dut1 (
        .eclk(eclk), .erst(erst), .bus(bus1)
    );

    always #5 eclk = ~eclk;

    // Expected tuple: {out[1:0], floating, decayed, changed, err_illegal}
    typedef struct {
        int         dut;
        logic [5:0] exp;
        string      name;
    } sb_t;

    sb_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam logic [7:0] Z    = 8'h00;
    localparam logic [7:0] ONE  = 8'b00_00_00_10;
    localparam logic [7:0] MIX  = 8'b00_00_01_10;
    localparam logic [7:0] ILL  = 8'b11_00_00_00;

    // Monitor: compares every expectation queued for the edge just taken.
    always @(negedge eclk) begin
        while (sb.size() > 0) begin
            sb_t e;
            logic [5:0] act;
            e = sb.pop_front();
            if (e.dut == 0)
                act = {bus0.out, bus0.floating, bus0.decayed, bus0.changed, bus0.err_illegal};
            else
                act = {bus1.out, bus1.floating, bus1.decayed, bus1.changed, bus1.err_illegal};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s dut%0d: got out=%b fl=%b dec=%b chg=%b err=%b, want out=%b fl=%b dec=%b chg=%b err=%b",
                         e.name, e.dut, act[5:4], act[3], act[2], act[1], act[0],
                         e.exp[5:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    end

    // One evaluation cycle; d = 0/1 selects a DUT to check, 2 = both, -1 = none.
    task automatic step(input logic rst, input logic en, input logic [7:0] iv,
                        input logic clr, input int d, input logic [1:0] eo,
                        input logic ef, input logic ed, input logic ec,
                        input logic ee, input string nm);
        sb_t e;
        @(negedge eclk);
        erst = rst;
        bus0.en = en;  bus1.en = en;
        bus0.i = iv;   bus1.i = iv;
        bus0.err_clr = clr; bus1.err_clr = clr;
        @(posedge eclk);
        e.exp  = {eo, ef, ed, ec, ee};
        e.name = nm;
        if (d == 0 || d == 2) begin e.dut = 0; sb.push_back(e); end
        if (d == 1 || d == 2) begin e.dut = 1; sb.push_back(e); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus0.en = 1'b0; bus1.en = 1'b0;
        bus0.i = '0;    bus1.i = '0;
        bus0.err_clr = 1'b0; bus1.err_clr = 1'b0;

        // Reset and basic resolution
        step(1, 0, Z,   0, 2, 2'b01, 0, 0, 0, 0, "reset");
        step(0, 1, ONE, 0, 2, 2'b10, 0, 0, 1, 0, "drive1");
        step(0, 1, ONE, 0, 2, 2'b10, 0, 0, 0, 0, "drive1_hold");
        step(0, 1, MIX, 0, 2, 2'b01, 0, 0, 1, 0, "pulldown_wins");
        step(0, 1, ONE, 0, 2, 2'b10, 0, 0, 1, 0, "redrive1");
        // No decay: charge held indefinitely
        for (int k = 0; k < 20; k++)
            step(0, 1, Z, 0, 0, 2'b10, 1, 0, 0, 0, "nodecay_hold");

        // Decay after 5 evaluated undriven cycles, en=0 cycles interleaved
        step(1, 0, Z,   0, 2, 2'b01, 0, 0, 0, 0, "reset2");
        step(0, 1, ONE, 0, 1, 2'b10, 0, 0, 1, 0, "decay_drive");
        step(0, 1, Z,   0, 1, 2'b10, 1, 0, 0, 0, "decay_u1");
        step(0, 0, Z,   0, 1, 2'b10, 1, 0, 0, 0, "decay_stall1");
        step(0, 1, Z,   0, 1, 2'b10, 1, 0, 0, 0, "decay_u2");
        step(0, 0, Z,   0, 1, 2'b10, 1, 0, 0, 0, "decay_stall2");
        step(0, 0, Z,   0, 1, 2'b10, 1, 0, 0, 0, "decay_stall3");
        step(0, 1, Z,   0, 1, 2'b10, 1, 0, 0, 0, "decay_u3");
        step(0, 1, Z,   0, 1, 2'b10, 1, 0, 0, 0, "decay_u4");
        step(0, 1, Z,   0, 1, 2'b01, 1, 1, 1, 0, "decay_u5");
        step(0, 1, Z,   0, 1, 2'b01, 1, 1, 0, 0, "decayed_hold");
        step(0, 1, ONE, 0, 1, 2'b10, 0, 0, 1, 0, "decay_redrive");

        // Sticky illegal flag, set beats clear, independent of en
        step(0, 0, ILL, 0, 2, 2'b10, 0, 0, 0, 1, "ill_set");
        step(0, 0, ILL, 1, 2, 2'b10, 0, 0, 0, 1, "ill_set_wins");
        step(0, 0, Z,   0, 2, 2'b10, 0, 0, 0, 1, "ill_sticky");
        step(0, 0, Z,   1, 2, 2'b10, 0, 0, 0, 0, "ill_clear");

        // Reset in FLOATING with counter=3, then decay count restarts
        step(0, 1, ONE, 0, 1, 2'b10, 0, 0, 0, 0, "mid_drive");
        step(0, 1, Z,   0, 1, 2'b10, 1, 0, 0, 0, "mid_u1");
        step(0, 1, Z,   0, 1, 2'b10, 1, 0, 0, 0, "mid_u2");
        step(0, 1, Z,   0, 1, 2'b10, 1, 0, 0, 0, "mid_u3");
        step(1, 1, Z,   0, 1, 2'b01, 0, 0, 0, 0, "mid_reset");
        step(0, 1, ONE, 0, 1, 2'b10, 0, 0, 1, 0, "post_drive");
        for (int k = 0; k < 4; k++)
            step(0, 1, Z, 0, 1, 2'b10, 1, 0, 0, 0, "post_undriven");
        step(0, 1, Z,   0, 1, 2'b01, 1, 1, 1, 0, "post_decay");

        // en=0 with a new driver: nothing moves, no change pulse
        step(0, 0, ONE, 0, 1, 2'b01, 1, 1, 0, 0, "en0_hold");

        @(negedge eclk);
        @(negedge eclk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
